// File: rtl/id_hazard_ctrl.sv
// ID-stage hazard control: register scoreboard, RAW/WAW stall, redirect flush.
// Define HAZ_WB_BYPASS_EN to let a same-cycle write-back release the hazard.
module id_hazard_ctrl #(
   parameter int NUM_REGS     = 32,
   parameter int REG_SEL      = $clog2(NUM_REGS),
   parameter int FLUSH_CYCLES = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                id_valid,
   input  logic [REG_SEL-1:0]  id_rs1,
   input  logic [REG_SEL-1:0]  id_rs2,
   input  logic [REG_SEL-1:0]  id_rd,
   input  logic                id_uses_rs2,
   input  logic                id_reg_write,
   input  logic                wb_reg_write,
   input  logic [REG_SEL-1:0]  wb_rd,
   input  logic                ex_redirect,
   output logic                stall,
   output logic                issue,
   output logic                flush_ifid,
   output logic                flush_idex,
   output logic [NUM_REGS-1:0] pending
);

   typedef enum logic {RUN, FLUSH} state_t;

   localparam logic [3:0] LP_LOAD = 4'(FLUSH_CYCLES - 1);

   state_t               r_state;
   state_t               w_state_nxt;
   logic [3:0]           r_cnt;
   logic [3:0]           w_cnt_nxt;
   logic [NUM_REGS-1:0]  r_pending;
   logic [NUM_REGS-1:0]  w_pend_nxt;
   logic [NUM_REGS-1:0]  w_busy;
   logic [NUM_REGS-1:0]  w_set;
   logic [NUM_REGS-1:0]  w_clr;
   logic [REG_SEL-1:0]   r_last_rd;
   logic                 r_last_set;
   logic                 w_hazard;
   logic                 w_flush;

   assign pending = r_pending;

   // Registers still in flight as seen by the decoder this cycle
   always_comb begin
      w_busy = r_pending;
`ifdef HAZ_WB_BYPASS_EN
      if (wb_reg_write) w_busy[wb_rd] = 1'b0;
`endif
      w_hazard = id_valid &
         (((id_rs1 != '0) & w_busy[id_rs1]) |
          (id_uses_rs2 & (id_rs2 != '0) & w_busy[id_rs2]) |
          (id_reg_write & (id_rd != '0) & w_busy[id_rd]));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= RUN;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // The redirect cycle itself is the first bubble, so FLUSH lasts one less
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      unique case (r_state)
         RUN: begin
            if (ex_redirect && (LP_LOAD != 4'd0)) begin
               w_state_nxt = FLUSH;
               w_cnt_nxt   = LP_LOAD;
            end
         end
         FLUSH: begin
            if (ex_redirect) begin
               w_cnt_nxt = LP_LOAD;
            end else if (r_cnt <= 4'd1) begin
               w_state_nxt = RUN;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         default: begin
            w_state_nxt = RUN;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_comb begin
      w_flush    = ex_redirect | (r_state == FLUSH);
      flush_ifid = w_flush;
      flush_idex = w_flush;
      stall      = w_hazard & ~w_flush;
      issue      = id_valid & ~w_hazard & ~w_flush;
   end

   // A writer squashed by the redirect never reaches write-back
   always_comb begin
      w_set = '0;
      w_clr = '0;
      if (issue & id_reg_write & (id_rd != '0)) w_set[id_rd] = 1'b1;
      if (wb_reg_write) w_clr[wb_rd] = 1'b1;
      if (ex_redirect & r_last_set) w_clr[r_last_rd] = 1'b1;
      w_pend_nxt    = (r_pending & ~w_clr) | w_set;
      w_pend_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pending  <= '0;
         r_last_rd  <= '0;
         r_last_set <= 1'b0;
      end else begin
         r_pending <= w_pend_nxt;
         if (issue) begin
            r_last_rd  <= id_rd;
            r_last_set <= id_reg_write & (id_rd != '0);
         end else begin
            r_last_rd  <= '0;
            r_last_set <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Scoreboard bench for id_hazard_ctrl: expected outputs are queued per
// driven cycle and compared when the combinational response is sampled.
module tb_id_hazard_ctrl;

   localparam logic [3:0] IDL = 4'b0000;
   localparam logic [3:0] ISS = 4'b0100;
   localparam logic [3:0] STL = 4'b1000;
   localparam logic [3:0] FLS = 4'b0011;

   typedef struct {
      string       nm;
      logic        r;
      logic        v;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        u2;
      logic [4:0]  rd;
      logic        rw;
      logic        wbw;
      logic [4:0]  wbrd;
      logic        redir;
      logic [3:0]  eo;
      logic [31:0] ep;
   } step_t;

   logic        clk;
   logic        rst;
   logic        id_valid;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic [4:0]  id_rd;
   logic        id_uses_rs2;
   logic        id_reg_write;
   logic        wb_reg_write;
   logic [4:0]  wb_rd;
   logic        ex_redirect;
   logic        stall;
   logic        issue;
   logic        flush_ifid;
   logic        flush_idex;
   logic [31:0] pending;

   int n_run;
   int n_fail;
   step_t sb[$];

   id_hazard_ctrl #(
      .NUM_REGS(32),
      .REG_SEL(5),
      .FLUSH_CYCLES(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .id_valid(id_valid),
      .id_rs1(id_rs1),
      .id_rs2(id_rs2),
      .id_rd(id_rd),
      .id_uses_rs2(id_uses_rs2),
      .id_reg_write(id_reg_write),
      .wb_reg_write(wb_reg_write),
      .wb_rd(wb_rd),
      .ex_redirect(ex_redirect),
      .stall(stall),
      .issue(issue),
      .flush_ifid(flush_ifid),
      .flush_idex(flush_idex),
      .pending(pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic step_t mk(
      input string nm, input int r, input int v,
      input int rs1, input int rs2, input int u2,
      input int rd, input int rw, input int wbw,
      input int wbrd, input int redir,
      input logic [3:0] eo, input int ep);
      step_t s;
      s.nm    = nm;
      s.r     = (r != 0);
      s.v     = (v != 0);
      s.rs1   = 5'(rs1);
      s.rs2   = 5'(rs2);
      s.u2    = (u2 != 0);
      s.rd    = 5'(rd);
      s.rw    = (rw != 0);
      s.wbw   = (wbw != 0);
      s.wbrd  = 5'(wbrd);
      s.redir = (redir != 0);
      s.eo    = eo;
      s.ep    = 32'(ep);
      return s;
   endfunction

   task automatic drive(input step_t s);
      rst          = s.r;
      id_valid     = s.v;
      id_rs1       = s.rs1;
      id_rs2       = s.rs2;
      id_uses_rs2  = s.u2;
      id_rd        = s.rd;
      id_reg_write = s.rw;
      wb_reg_write = s.wbw;
      wb_rd        = s.wbrd;
      ex_redirect  = s.redir;
      sb.push_back(s);
   endtask

   task automatic test_reset();
      step_t st[$];
      step_t e;
      st.push_back(mk("rst_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDL, 0));
      st.push_back(mk("rst_valid", 0, 1, 5, 6, 1, 7, 1, 0, 0, 0, ISS, 0));
      st.push_back(mk("rst_wb", 0, 1, 3, 0, 0, 3, 1, 1, 3, 0, ISS, 0));
      st.push_back(mk("rst_rel", 1, 1, 5, 6, 1, 0, 0, 0, 0, 0, ISS, 0));
      while (st.size() > 0) begin
         drive(st.pop_front());
         @(negedge clk);
         e = sb.pop_front();
         n_run++;
         if ({stall, issue, flush_ifid, flush_idex} !== e.eo) begin
            n_fail++;
            $display("FAIL %s ctl got %b want %b", e.nm,
                     {stall, issue, flush_ifid, flush_idex}, e.eo);
         end
         n_run++;
         if (pending !== e.ep) begin
            n_fail++;
            $display("FAIL %s pending got %h want %h", e.nm, pending, e.ep);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_raw();
      step_t st[$];
      step_t e;
      st.push_back(mk("raw_w5", 1, 1, 1, 2, 1, 5, 1, 0, 0, 0, ISS, 0));
      st.push_back(mk("raw_stall", 1, 1, 5, 0, 0, 6, 1, 0, 0, 0, STL, 'h20));
`ifdef HAZ_WB_BYPASS_EN
      st.push_back(mk("raw_wb", 1, 1, 5, 0, 0, 6, 1, 1, 5, 0, ISS, 'h20));
      st.push_back(mk("raw_idle", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDL, 'h40));
`else
      st.push_back(mk("raw_wb", 1, 1, 5, 0, 0, 6, 1, 1, 5, 0, STL, 'h20));
      st.push_back(mk("raw_rel", 1, 1, 5, 0, 0, 6, 1, 0, 0, 0, ISS, 0));
`endif
      st.push_back(mk("raw_clr6", 1, 0, 0, 0, 0, 0, 0, 1, 6, 0, IDL, 'h40));
      st.push_back(mk("raw_end", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDL, 0));
      while (st.size() > 0) begin
         drive(st.pop_front());
         @(negedge clk);
         e = sb.pop_front();
         n_run++;
         if ({stall, issue, flush_ifid, flush_idex} !== e.eo) begin
            n_fail++;
            $display("FAIL %s ctl got %b want %b", e.nm,
                     {stall, issue, flush_ifid, flush_idex}, e.eo);
         end
         n_run++;
         if (pending !== e.ep) begin
            n_fail++;
            $display("FAIL %s pending got %h want %h", e.nm, pending, e.ep);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_rs2_waw();
      step_t st[$];
      step_t e;
      st.push_back(mk("w9", 1, 1, 0, 0, 0, 9, 1, 0, 0, 0, ISS, 0));
      st.push_back(mk("rs2_imm", 1, 1, 1, 9, 0, 0, 0, 0, 0, 0, ISS, 'h200));
      st.push_back(mk("rs2_raw", 1, 1, 1, 9, 1, 0, 0, 0, 0, 0, STL, 'h200));
      st.push_back(mk("waw", 1, 1, 1, 2, 1, 9, 1, 0, 0, 0, STL, 'h200));
      st.push_back(mk("rd_nowr", 1, 1, 2, 0, 0, 9, 0, 0, 0, 0, ISS, 'h200));
      st.push_back(mk("clr9", 1, 0, 0, 0, 0, 0, 0, 1, 9, 0, IDL, 'h200));
      st.push_back(mk("w9_end", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDL, 0));
      while (st.size() > 0) begin
         drive(st.pop_front());
         @(negedge clk);
         e = sb.pop_front();
         n_run++;
         if ({stall, issue, flush_ifid, flush_idex} !== e.eo) begin
            n_fail++;
            $display("FAIL %s ctl got %b want %b", e.nm,
                     {stall, issue, flush_ifid, flush_idex}, e.eo);
         end
         n_run++;
         if (pending !== e.ep) begin
            n_fail++;
            $display("FAIL %s pending got %h want %h", e.nm, pending, e.ep);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_x0();
      step_t st[$];
      step_t e;
      for (int i = 0; i < 3; i++)
         st.push_back(mk("x0_wr", 1, 1, 0, 0, 1, 0, 1, 0, 0, 0, ISS, 0));
      st.push_back(mk("x0_end", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDL, 0));
      while (st.size() > 0) begin
         drive(st.pop_front());
         @(negedge clk);
         e = sb.pop_front();
         n_run++;
         if ({stall, issue, flush_ifid, flush_idex} !== e.eo) begin
            n_fail++;
            $display("FAIL %s ctl got %b want %b", e.nm,
                     {stall, issue, flush_ifid, flush_idex}, e.eo);
         end
         n_run++;
         if (pending !== e.ep) begin
            n_fail++;
            $display("FAIL %s pending got %h want %h", e.nm, pending, e.ep);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_flush();
      step_t st[$];
      step_t e;
      st.push_back(mk("fl_redir", 1, 1, 1, 0, 0, 2, 0, 0, 0, 1, FLS, 0));
      st.push_back(mk("fl_hold", 1, 1, 1, 0, 0, 2, 0, 0, 0, 0, FLS, 0));
      st.push_back(mk("fl_done", 1, 1, 1, 0, 0, 2, 0, 0, 0, 0, ISS, 0));
      st.push_back(mk("rl_redir", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, FLS, 0));
      st.push_back(mk("rl_again", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, FLS, 0));
      st.push_back(mk("rl_hold", 1, 1, 1, 0, 0, 2, 0, 0, 0, 0, FLS, 0));
      st.push_back(mk("rl_done", 1, 1, 1, 0, 0, 2, 0, 0, 0, 0, ISS, 0));
      while (st.size() > 0) begin
         drive(st.pop_front());
         @(negedge clk);
         e = sb.pop_front();
         n_run++;
         if ({stall, issue, flush_ifid, flush_idex} !== e.eo) begin
            n_fail++;
            $display("FAIL %s ctl got %b want %b", e.nm,
                     {stall, issue, flush_ifid, flush_idex}, e.eo);
         end
         n_run++;
         if (pending !== e.ep) begin
            n_fail++;
            $display("FAIL %s pending got %h want %h", e.nm, pending, e.ep);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_squash();
      step_t st[$];
      step_t e;
      st.push_back(mk("sq_w7", 1, 1, 0, 0, 0, 7, 1, 0, 0, 0, ISS, 0));
      st.push_back(mk("sq_redir", 1, 1, 7, 0, 0, 0, 0, 0, 0, 1, FLS, 'h80));
      st.push_back(mk("sq_hold", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, FLS, 0));
      st.push_back(mk("sq_use7", 1, 1, 7, 0, 0, 0, 0, 0, 0, 0, ISS, 0));
      st.push_back(mk("sq_end", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDL, 0));
      while (st.size() > 0) begin
         drive(st.pop_front());
         @(negedge clk);
         e = sb.pop_front();
         n_run++;
         if ({stall, issue, flush_ifid, flush_idex} !== e.eo) begin
            n_fail++;
            $display("FAIL %s ctl got %b want %b", e.nm,
                     {stall, issue, flush_ifid, flush_idex}, e.eo);
         end
         n_run++;
         if (pending !== e.ep) begin
            n_fail++;
            $display("FAIL %s pending got %h want %h", e.nm, pending, e.ep);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_set_wins();
      step_t st[$];
      step_t e;
      st.push_back(mk("sw_both", 1, 1, 0, 0, 0, 3, 1, 1, 3, 0, ISS, 0));
      st.push_back(mk("sw_clr4", 1, 0, 0, 0, 0, 0, 0, 1, 4, 0, IDL, 'h8));
      st.push_back(mk("sw_clr3", 1, 0, 0, 0, 0, 0, 0, 1, 3, 0, IDL, 'h8));
      st.push_back(mk("sw_end", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDL, 0));
      while (st.size() > 0) begin
         drive(st.pop_front());
         @(negedge clk);
         e = sb.pop_front();
         n_run++;
         if ({stall, issue, flush_ifid, flush_idex} !== e.eo) begin
            n_fail++;
            $display("FAIL %s ctl got %b want %b", e.nm,
                     {stall, issue, flush_ifid, flush_idex}, e.eo);
         end
         n_run++;
         if (pending !== e.ep) begin
            n_fail++;
            $display("FAIL %s pending got %h want %h", e.nm, pending, e.ep);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset_flush();
      step_t st[$];
      step_t e;
      st.push_back(mk("rf_w4", 1, 1, 0, 0, 0, 4, 1, 0, 0, 0, ISS, 0));
      st.push_back(mk("rf_w5", 1, 1, 0, 0, 0, 5, 1, 0, 0, 0, ISS, 'h10));
      st.push_back(mk("rf_w6", 1, 1, 0, 0, 0, 6, 1, 0, 0, 0, ISS, 'h30));
      st.push_back(mk("rf_w7", 1, 1, 0, 0, 0, 7, 1, 0, 0, 0, ISS, 'h70));
      st.push_back(mk("rf_idle", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDL, 'hF0));
      st.push_back(mk("rf_redir", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, FLS, 'hF0));
      st.push_back(mk("rf_rst", 0, 1, 4, 0, 0, 0, 0, 0, 0, 0, ISS, 0));
      st.push_back(mk("rf_rel", 1, 1, 4, 0, 0, 0, 0, 0, 0, 0, ISS, 0));
      st.push_back(mk("rf_end", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDL, 0));
      while (st.size() > 0) begin
         drive(st.pop_front());
         @(negedge clk);
         e = sb.pop_front();
         n_run++;
         if ({stall, issue, flush_ifid, flush_idex} !== e.eo) begin
            n_fail++;
            $display("FAIL %s ctl got %b want %b", e.nm,
                     {stall, issue, flush_ifid, flush_idex}, e.eo);
         end
         n_run++;
         if (pending !== e.ep) begin
            n_fail++;
            $display("FAIL %s pending got %h want %h", e.nm, pending, e.ep);
         end
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      n_run        = 0;
      n_fail       = 0;
      rst          = 1'b0;
      id_valid     = 1'b0;
      id_rs1       = '0;
      id_rs2       = '0;
      id_rd        = '0;
      id_uses_rs2  = 1'b0;
      id_reg_write = 1'b0;
      wb_reg_write = 1'b0;
      wb_rd        = '0;
      ex_redirect  = 1'b0;
      #1;
      test_reset();
      test_raw();
      test_rs2_waw();
      test_x0();
      test_flush();
      test_squash();
      test_set_wins();
      test_reset_flush();
      n_run++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain left %0d want 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/id_hazard_ctrl.md
ID_HAZARD_CTRL -- requirements
Module: id_hazard_ctrl

Interface
REQ-001 Parameter NUM_REGS, 32, architectural register count.
REQ-002 Parameter REG_SEL, $clog2(NUM_REGS), register select width.
REQ-003 Parameter FLUSH_CYCLES, 2, bubble cycles inserted after a redirect (1..15).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 id_valid  in  1  ID stage holds a valid instruction.
REQ-007 id_rs1 / id_rs2 / id_rd  in  REG_SEL each  source/destination selects from decoder.
REQ-008 id_uses_rs2  in  1  instruction reads rs2 (0 when immediate form).
REQ-009 id_reg_write  in  1  instruction writes regfile.
REQ-010 wb_reg_write  in  1, wb_rd  in  REG_SEL  write-back port into regfile.
REQ-011 ex_redirect  in  1  EX resolved taken branch/jump this cycle.
REQ-012 stall  out  1  hold PC and IF/ID register.
REQ-013 issue  out  1  ID instruction advances into ID/EX this cycle.
REQ-014 flush_ifid / flush_idex  out  1 each  squash IF/ID and ID/EX contents.
REQ-015 pending  out  NUM_REGS  scoreboard bit per register, bit 0 always 0.

Function
REQ-016 Scoreboard bit r SHALL set on the edge where issue=1, id_reg_write=1, id_rd=r, r!=0.
REQ-017 Bit r SHALL clear on the edge where wb_reg_write=1 and wb_rd=r.
REQ-018 Simultaneous set and clear of the same bit: set wins.
REQ-019 Hazard = id_valid & ((id_rs1!=0 & pending[id_rs1]) | (id_uses_rs2 & id_rs2!=0 & pending[id_rs2]) | (id_reg_write & id_rd!=0 & pending[id_rd])) (RAW + WAW).
REQ-020 Control FSM states RUN and FLUSH; RUN->FLUSH on ex_redirect, counter loaded with FLUSH_CYCLES-1.
REQ-021 In FLUSH counter decrements each cycle; FLUSH->RUN on the cycle counter=0; ex_redirect in FLUSH reloads counter.
REQ-022 flush_ifid = flush_idex = 1 combinationally when ex_redirect=1 or state=FLUSH; else 0.
REQ-023 stall = hazard & ~flush_ifid; issue = id_valid & ~hazard & ~flush_ifid.
REQ-024 Block SHALL register last_rd/last_set (rd and whether a bit was set by the most recent issue); cleared when no issue occurs.
REQ-025 On ex_redirect with last_set=1, pending[last_rd] SHALL clear on that edge (squashed writer never writes back), unless a new set targets it in the same edge.
REQ-026 Outputs stall/issue/flush are combinational, zero-cycle latency; scoreboard visible one cycle after issue.

Reset
REQ-027 rst low SHALL asynchronously clear pending, last_rd, last_set, counter, and force state RUN.
REQ-028 During and immediately after reset: stall=0, flush_ifid=flush_idex=0, issue=id_valid (scoreboard empty).
REQ-029 Reset asserted mid-FLUSH SHALL abort the flush; no residual bubble after release.

Configuration
REQ-030 Macro HAZ_WB_BYPASS_EN: when defined, a source/destination matching wb_rd with wb_reg_write=1 in the same cycle SHALL NOT count as hazard (regfile write-through assumed).
REQ-031 Without HAZ_WB_BYPASS_EN, such a match SHALL stall one more cycle until the bit is clear.

Verification
REQ-032 Issue x5 writer, next cycle id_rs1=5 -> stall=1, issue=0 until wb_rd=5 edge; bypass build: released that cycle, else one cycle later.
REQ-033 id_rs1=0, id_rd=0 writes repeatedly -> pending stays 0, stall never asserted.
REQ-034 ex_redirect single pulse, FLUSH_CYCLES=2 -> flush outputs high 2 cycles (redirect cycle + 1), issue=0 throughout.
REQ-035 Issue x7 writer then ex_redirect next cycle -> pending[7]=0 after edge; later id_rs1=7 issues without stall.
REQ-036 wb_rd=3 clear and new issue with id_rd=3 same edge -> pending[3]=1.
REQ-037 rst low during FLUSH with pending=0x0000_00F0 -> pending=0, flush=0 immediately, RUN after release.
